// File: rtl/sseg_pkg.sv
// Shared types and constants for the two-digit 7-segment scan driver.
// Pure declarations: no latency, no flow control.
package sseg_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SHOW_FIRST,
    ST_BLANK_A,
    ST_SHOW_SECOND,
    ST_BLANK_B
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;
  localparam logic [3:0] AN_TENS   = 4'b1101;
  localparam logic [3:0] AN_UNITS  = 4'b1110;

  // Counter width for a modulo-n count, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sseg_pulse_div.sv
// Wrapping counter: tc is high on the cycle the count equals last; count wraps to 0 on that edge.
// Synchronous clear wins over counting; no backpressure.
module sseg_pulse_div
  import sseg_pkg::*;
#(
  parameter int DIV = 2,
  localparam int W = cnt_width(DIV)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt;

  assign tc = en && (cnt == last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexes two captured 7-seg patterns onto a shared cathode bus with blanking and blink.
// seg/an registered, updated on the edge that enters a state; no backpressure (free-running scan).
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_HZ     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       blink,
  input  logic [6:0] ssegFirst,
  input  logic [6:0] ssegSecond,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int TMAX  = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
  localparam int TW    = cnt_width(TMAX);
  localparam int BW    = cnt_width(HALF);

  state_t     state, nxt;
  logic       ttc, btc;
  logic [TW-1:0] tlast;
  logic       capture;
  logic [6:0] shadow_first, shadow_second;
  logic       phase_on, phase_nxt;
  logic [6:0] seg_d;
  logic [3:0] an_d;

  // One timer serves both dwell and blank; its terminal value follows the current state.
  assign tlast = (state == ST_SHOW_FIRST || state == ST_SHOW_SECOND) ?
                 TW'(DWELL - 1) : TW'(BLANK_CYCLES - 1);

  sseg_pulse_div #(.DIV(TMAX)) u_scan_timer (
    .clk   (clk),
    .reset (reset),
    .en    (state != ST_OFF),
    .clr   ((state == ST_OFF) || !enable),
    .last  (tlast),
    .tc    (ttc)
  );

  sseg_pulse_div #(.DIV(HALF)) u_blink_timer (
    .clk   (clk),
    .reset (reset),
    .en    (blink),
    .clr   (!blink),
    .last  (BW'(HALF - 1)),
    .tc    (btc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_OFF;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    if (!enable) begin
      nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF:         nxt = ST_SHOW_FIRST;
        ST_SHOW_FIRST:  if (ttc) nxt = ST_BLANK_A;
        ST_BLANK_A:     if (ttc) nxt = ST_SHOW_SECOND;
        ST_SHOW_SECOND: if (ttc) nxt = ST_BLANK_B;
        ST_BLANK_B:     if (ttc) nxt = ST_SHOW_FIRST;
        default:        nxt = ST_OFF;
      endcase
    end
  end

  assign capture   = (nxt == ST_SHOW_FIRST) && (state != ST_SHOW_FIRST);
  assign phase_nxt = !blink ? 1'b1 : (btc ? !phase_on : phase_on);

  // Outputs are precomputed from the next state so they switch on the entering edge.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    case (nxt)
      ST_SHOW_FIRST: begin
        seg_d = capture ? ssegFirst : shadow_first;
        an_d  = AN_TENS;
      end
      ST_SHOW_SECOND: begin
        seg_d = shadow_second;
        an_d  = AN_UNITS;
      end
      default: begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
      end
    endcase
    if (!phase_nxt) begin
      seg_d = SEG_BLANK;
      an_d  = AN_OFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_first  <= SEG_BLANK;
      shadow_second <= SEG_BLANK;
    end else if (capture) begin
      shadow_first  <= ssegFirst;
      shadow_second <= ssegSecond;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg      <= SEG_BLANK;
      an       <= AN_OFF;
      phase_on <= 1'b1;
    end else begin
      seg      <= seg_d;
      an       <= an_d;
      phase_on <= phase_nxt;
    end
  end

  // Decoded purely from registered state; an aborted frame never reaches this cycle.
  assign frame_tick = (state == ST_BLANK_B) && ttc;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed plus randomized checks of sseg_scan_driver against a frame-position reference model.
module tb_sseg_scan_driver;

  localparam int D = 10;
  localparam int B = 2;
  localparam int F = 2 * (D + B);
  localparam int H = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       blink;
  logic [6:0] ssegFirst;
  logic [6:0] ssegSecond;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;

  // reference model: frame position, snapshot, consecutive blink cycles
  bit         m_on = 0;
  int         m_pos = 0;
  logic [6:0] m_s1 = 7'h7F;
  logic [6:0] m_s2 = 7'h7F;
  int         m_k = 0;
  int         cyc = 0;
  int         last_tick = -1;
  bit         cadence_on = 0;

  sseg_scan_driver #(
    .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2), .BLINK_HZ(10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .blink      (blink),
    .ssegFirst  (ssegFirst),
    .ssegSecond (ssegSecond),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [6:0] es;
    logic [3:0] ea;
    logic       et;
    es = 7'h7F;
    ea = 4'hF;
    et = 1'b0;
    if (m_on) begin
      if (m_pos < D) begin
        es = m_s1;
        ea = 4'b1101;
      end else if (m_pos >= D + B && m_pos < 2 * D + B) begin
        es = m_s2;
        ea = 4'b1110;
      end
      et = (m_pos == F - 1);
    end
    if (((m_k / H) % 2) == 1) begin
      es = 7'h7F;
      ea = 4'hF;
    end
    chk("seg", 32'(seg), 32'(es));
    chk("an", 32'(an), 32'(ea));
    chk("frame_tick", 32'(frame_tick), 32'(et));
    chk("an_upper", 32'(an[3:2]), 32'(2'b11));
    chk("an_both_on", 32'(an == 4'b1100), 32'(0));
    if (cadence_on && frame_tick) begin
      if (last_tick >= 0) chk("tick_cadence", 32'(cyc - last_tick), 32'(F));
      last_tick = cyc;
    end
  endtask

  // One clock: model advances with the inputs held across the edge, outputs checked at negedge.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_on = 0;
      m_k  = 0;
    end else begin
      if (!enable) begin
        m_on = 0;
      end else if (!m_on) begin
        m_on  = 1;
        m_pos = 0;
        m_s1  = ssegFirst;
        m_s2  = ssegSecond;
      end else begin
        m_pos = (m_pos + 1) % F;
        if (m_pos == 0) begin
          m_s1 = ssegFirst;
          m_s2 = ssegSecond;
        end
      end
      m_k = blink ? m_k + 1 : 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_to(input int p);
    int budget;
    budget = 4 * F;
    step();
    while (m_pos != p && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      total++;
      bad++;
      $error("FAIL run_to observed=%0d expected=%0d", m_pos, p);
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    blink      = 1'b0;
    ssegFirst  = 7'h00;
    ssegSecond = 7'h00;

    // reset state
    @(negedge clk);
    check_outputs();
    step();
    reset = 1'b0;

    // 1: steady scan
    ssegFirst  = 7'b100_1111;
    ssegSecond = 7'b000_0001;
    enable     = 1'b1;
    step();
    chk("first_show_an", 32'(an), 32'(4'b1101));
    chk("first_show_seg", 32'(seg), 32'(7'b100_1111));
    repeat (2 * F - 1) step();

    // 2: mid-frame change only visible next frame
    run_to(3);
    ssegSecond = 7'b001_0010;
    run_to(D + B);
    chk("old_snapshot", 32'(seg), 32'(7'b000_0001));
    run_to(D + B);
    chk("new_snapshot", 32'(seg), 32'(7'b001_0010));

    // 3: blink window, tick cadence unaffected
    cadence_on = 1;
    last_tick  = -1;
    blink      = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i % 37 == 5) ssegFirst = 7'($urandom);
      step();
    end
    blink = 1'b0;
    repeat (F + 2) step();
    cadence_on = 0;

    // 4: abort during SHOW_SECOND
    run_to(D + B + 5);
    enable = 1'b0;
    step();
    chk("abort_dark_an", 32'(an), 32'(4'hF));
    chk("abort_no_tick", 32'(frame_tick), 32'(0));
    repeat (3) step();
    ssegFirst  = 7'($urandom);
    ssegSecond = 7'($urandom);
    enable     = 1'b1;
    step();
    chk("restart_capture", 32'(seg), 32'(ssegFirst));
    repeat (F + 4) step();

    // 5: async reset between edges
    run_to(3);
    #2 reset = 1'b1;
    #1;
    chk("async_seg", 32'(seg), 32'(7'h7F));
    chk("async_an", 32'(an), 32'(4'hF));
    step();
    reset = 1'b0;
    step();
    chk("resume_an", 32'(an), 32'(4'b1101));
    chk("resume_seg", 32'(seg), 32'(ssegFirst));

    // randomized soak
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 79) == 0) blink = ~blink;
      if ($urandom_range(0, 7) == 0) ssegFirst = 7'($urandom);
      if ($urandom_range(0, 7) == 0) ssegSecond = 7'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
